// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory target with fixed wait states.
// Handshake: req_valid/req_ready in, resp_valid/resp_ready out.
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid, req_ready, req_we, req_addr, req_wdata, req_wstrb
//   resp_valid, resp_ready, resp_rdata, resp_err
// Build option: define MEM_RESP_ERR_EN to fault misaligned or
// out-of-range accesses; otherwise the word index wraps.

module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  state_t        state;
  state_t        state_nx;
  logic [3:0]    cnt;
  logic [3:0]    cnt_nx;
  req_t          lat;
  req_t          acc;
  logic          accept;
  logic          access;
  logic [AW-1:0] idx;
  logic          fault;
  logic [31:0]   mem [DEPTH_WORDS];

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;

  // With no wait states the access happens on the accept
  // edge itself, so it must see the live request.
  assign acc = (state == IDLE)
             ? {req_we, req_addr, req_wdata, req_wstrb}
             : lat;

  assign idx = acc.addr[AW+1:2];

`ifdef MEM_RESP_ERR_EN
  assign fault = (acc.addr[1:0] != 2'b00) ||
                 ({2'b00, acc.addr[31:2]} >= 32'(DEPTH_WORDS));
`else
  logic unused_addr;
  assign unused_addr = ^{acc.addr[31:AW+2], acc.addr[1:0]};
  assign fault       = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    access   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          cnt_nx = WAIT_LD;
          if (WAIT_CYCLES == 0) begin
            state_nx = RESP;
            access   = 1'b1;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt <= 4'd1) begin
          state_nx = RESP;
          cnt_nx   = 4'd0;
          access   = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
      end
    endcase
    // Accesses never happen while reset is held low.
    access = access & reset;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      lat        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        lat <= acc;
      end
      if (access) begin
        resp_valid <= 1'b1;
        resp_err   <= fault;
        resp_rdata <= (acc.we || fault) ? 32'd0 : mem[idx];
      end else if (resp_valid && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (access && acc.we && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (acc.wstrb[i]) begin
          mem[idx][8*i +: 8] <= acc.wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks for mem_responder.
// Instance a uses two wait states, instance b uses none.

module tb_mem_responder;

  localparam int DEPTH = 64;

  logic        clk;
  logic        reset;

  logic        a_req_valid;
  logic        a_req_ready;
  logic        a_req_we;
  logic [31:0] a_req_addr;
  logic [31:0] a_req_wdata;
  logic [3:0]  a_req_wstrb;
  logic        a_resp_valid;
  logic        a_resp_ready;
  logic [31:0] a_resp_rdata;
  logic        a_resp_err;

  logic        b_req_valid;
  logic        b_req_ready;
  logic        b_req_we;
  logic [31:0] b_req_addr;
  logic [31:0] b_req_wdata;
  logic [3:0]  b_req_wstrb;
  logic        b_resp_valid;
  logic        b_resp_ready;
  logic [31:0] b_resp_rdata;
  logic        b_resp_err;

  int n_chk;
  int n_fail;

  mem_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(2)
  ) u_a (
    .clk       (clk),
    .reset     (reset),
    .req_valid (a_req_valid),
    .req_ready (a_req_ready),
    .req_we    (a_req_we),
    .req_addr  (a_req_addr),
    .req_wdata (a_req_wdata),
    .req_wstrb (a_req_wstrb),
    .resp_valid(a_resp_valid),
    .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata),
    .resp_err  (a_resp_err)
  );

  mem_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(0)
  ) u_b (
    .clk       (clk),
    .reset     (reset),
    .req_valid (b_req_valid),
    .req_ready (b_req_ready),
    .req_we    (b_req_we),
    .req_addr  (b_req_addr),
    .req_wdata (b_req_wdata),
    .req_wstrb (b_req_wstrb),
    .resp_valid(b_resp_valid),
    .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata),
    .resp_err  (b_resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag,
                      input logic obs,
                      input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One full transaction on instance a with exact latency checks.
  task automatic a_xact(input string       tag,
                        input logic        we,
                        input logic [31:0] addr,
                        input logic [31:0] wdata,
                        input logic [3:0]  wstrb,
                        input logic [31:0] exp_rdata,
                        input logic        exp_err);
    chk1({tag, ":rdy"}, a_req_ready, 1'b1);
    a_req_valid  = 1'b1;
    a_req_we     = we;
    a_req_addr   = addr;
    a_req_wdata  = wdata;
    a_req_wstrb  = wstrb;
    a_resp_ready = 1'b1;
    step();
    a_req_valid = 1'b0;
    chk1({tag, ":w0"}, a_resp_valid, 1'b0);
    step();
    chk1({tag, ":w1"}, a_resp_valid, 1'b0);
    step();
    chk1({tag, ":vld"}, a_resp_valid, 1'b1);
    chk32({tag, ":rdata"}, a_resp_rdata, exp_rdata);
    chk1({tag, ":err"}, a_resp_err, exp_err);
    step();
    chk1({tag, ":done"}, a_resp_valid, 1'b0);
    chk1({tag, ":idle"}, a_req_ready, 1'b1);
  endtask

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    reset        = 1'b0;
    a_req_valid  = 1'b0;
    a_req_we     = 1'b0;
    a_req_addr   = 32'd0;
    a_req_wdata  = 32'd0;
    a_req_wstrb  = 4'd0;
    a_resp_ready = 1'b0;
    b_req_valid  = 1'b0;
    b_req_we     = 1'b0;
    b_req_addr   = 32'd0;
    b_req_wdata  = 32'd0;
    b_req_wstrb  = 4'd0;
    b_resp_ready = 1'b0;

    step();
    step();
    chk1("rst:ready", a_req_ready, 1'b1);
    chk1("rst:valid", a_resp_valid, 1'b0);
    chk32("rst:rdata", a_resp_rdata, 32'd0);
    chk1("rst:err", a_resp_err, 1'b0);
    chk1("rst:b_valid", b_resp_valid, 1'b0);
    reset = 1'b1;
    step();

    a_xact("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0);
    a_xact("ld10", 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEADBEEF, 1'b0);
    a_xact("stb0", 1'b1, 32'h10, 32'h000000AA, 4'h1, 32'd0, 1'b0);
    a_xact("ldb0", 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEADBEAA, 1'b0);
    a_xact("stb12", 1'b1, 32'h10, 32'h12345678, 4'h6, 32'd0, 1'b0);
    a_xact("ldb12", 1'b0, 32'h10, 32'd0, 4'h0, 32'hDE3456AA, 1'b0);
    a_xact("stnop", 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'd0, 1'b0);
    a_xact("ldnop", 1'b0, 32'h10, 32'd0, 4'h0, 32'hDE3456AA, 1'b0);
    a_xact("st14", 1'b1, 32'h14, 32'hCAFEF00D, 4'hF, 32'd0, 1'b0);
    a_xact("ld14", 1'b0, 32'h14, 32'd0, 4'h0, 32'hCAFEF00D, 1'b0);

    // Back-pressure: response held, stray request ignored.
    chk1("bp:rdy", a_req_ready, 1'b1);
    a_req_valid  = 1'b1;
    a_req_we     = 1'b0;
    a_req_addr   = 32'h14;
    a_resp_ready = 1'b0;
    step();
    a_req_we    = 1'b1;
    a_req_wdata = 32'd0;
    a_req_wstrb = 4'hF;
    chk1("bp:wait_rdy", a_req_ready, 1'b0);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk1("bp:valid", a_resp_valid, 1'b1);
      chk32("bp:rdata", a_resp_rdata, 32'hCAFEF00D);
      chk1("bp:rdy", a_req_ready, 1'b0);
      step();
    end
    a_resp_ready = 1'b1;
    step();
    a_req_valid = 1'b0;
    chk1("bp:done", a_resp_valid, 1'b0);
    chk1("bp:idle", a_req_ready, 1'b1);
    chk32("bp:keep", a_resp_rdata, 32'hCAFEF00D);
    chk1("bp:err", a_resp_err, 1'b0);
    a_xact("bp:ld14", 1'b0, 32'h14, 32'd0, 4'h0, 32'hCAFEF00D, 1'b0);

    // Reset during WAIT abandons the store; reset blocks accepts.
    a_xact("st20", 1'b1, 32'h20, 32'h01020304, 4'hF, 32'd0, 1'b0);
    a_xact("st40", 1'b1, 32'h40, 32'hA5A5A5A5, 4'hF, 32'd0, 1'b0);
    a_req_valid = 1'b1;
    a_req_we    = 1'b1;
    a_req_addr  = 32'h20;
    a_req_wdata = 32'hFFFFFFFF;
    a_req_wstrb = 4'hF;
    step();
    a_req_valid = 1'b0;
    chk1("ra:wait", a_req_ready, 1'b0);
    step();
    reset       = 1'b0;
    a_req_valid = 1'b1;
    a_req_addr  = 32'h40;
    a_req_wdata = 32'h55555555;
    #1;
    chk1("ra:valid", a_resp_valid, 1'b0);
    chk1("ra:rdy", a_req_ready, 1'b1);
    chk32("ra:rdata", a_resp_rdata, 32'd0);
    step();
    step();
    chk1("ra:valid2", a_resp_valid, 1'b0);
    a_req_valid = 1'b0;
    reset       = 1'b1;
    step();
    chk1("ra:post", a_resp_valid, 1'b0);
    a_xact("ra:ld20", 1'b0, 32'h20, 32'd0, 4'h0, 32'h01020304, 1'b0);
    a_xact("ra:ld40", 1'b0, 32'h40, 32'd0, 4'h0, 32'hA5A5A5A5, 1'b0);

    // Address checking or wrapping.
    a_xact("st00", 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 32'd0, 1'b0);
`ifdef MEM_RESP_ERR_EN
    a_xact("e:ld13", 1'b0, 32'h13, 32'd0, 4'h0, 32'd0, 1'b1);
    a_xact("e:stoor", 1'b1, 32'h100, 32'h99, 4'hF, 32'd0, 1'b1);
    a_xact("e:ld00", 1'b0, 32'h0, 32'd0, 4'h0, 32'h0BADF00D, 1'b0);
    a_xact("e:ldoor", 1'b0, 32'h100, 32'd0, 4'h0, 32'd0, 1'b1);
`else
    a_xact("w:ld13", 1'b0, 32'h13, 32'd0, 4'h0, 32'hDE3456AA, 1'b0);
    a_xact("w:st100", 1'b1, 32'h100, 32'h99, 4'hF, 32'd0, 1'b0);
    a_xact("w:ld00", 1'b0, 32'h0, 32'd0, 4'h0, 32'h00000099, 1'b0);
`endif

    // Zero wait states: accept every second cycle.
    b_resp_ready = 1'b1;
    chk1("b:rdy0", b_req_ready, 1'b1);
    b_req_valid = 1'b1;
    b_req_we    = 1'b1;
    b_req_addr  = 32'h8;
    b_req_wdata = 32'h11223344;
    b_req_wstrb = 4'hF;
    step();
    chk1("b:v0", b_resp_valid, 1'b1);
    chk1("b:r0", b_req_ready, 1'b0);
    chk32("b:d0", b_resp_rdata, 32'd0);
    chk1("b:e0", b_resp_err, 1'b0);
    b_req_we = 1'b0;
    step();
    chk1("b:v1", b_resp_valid, 1'b0);
    chk1("b:r1", b_req_ready, 1'b1);
    step();
    chk1("b:v2", b_resp_valid, 1'b1);
    chk32("b:d2", b_resp_rdata, 32'h11223344);
    b_req_we    = 1'b1;
    b_req_wdata = 32'hAA000000;
    b_req_wstrb = 4'h8;
    step();
    chk1("b:v3", b_resp_valid, 1'b0);
    step();
    chk1("b:v4", b_resp_valid, 1'b1);
    chk32("b:d4", b_resp_rdata, 32'd0);
    b_req_we = 1'b0;
    step();
    chk1("b:r5", b_req_ready, 1'b1);
    step();
    chk1("b:v6", b_resp_valid, 1'b1);
    chk32("b:d6", b_resp_rdata, 32'hAA223344);
    b_req_valid = 1'b0;
    step();
    chk1("b:v7", b_resp_valid, 1'b0);
    chk1("b:r7", b_req_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
